// File: rtl/mux81_pkg.sv
// mux81_pkg: shared definitions for the 8:1 round-robin mux scheduler.
//   NREQ    - number of requesters
//   SELW    - width of the select index
//   state_t - scheduler state
//   rr_pick - round-robin winner search returning {found, idx}
package mux81_pkg;

    localparam int unsigned NREQ = 8;
    localparam int unsigned SELW = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Scans start, start+1, ... start+7 (mod 8). The scan runs backwards so
    // that the last match overwritten is the first candidate in round-robin order.
    function automatic logic [SELW:0] rr_pick(input logic [NREQ-1:0] req,
                                             input logic [SELW-1:0] start);
        logic [SELW:0]   res;
        logic [SELW-1:0] idx;
        res = '0;
        for (int unsigned k = NREQ; k > 0; k--) begin
            idx = start + SELW'(k - 1);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux81.sv
// mux81: plain 8:1 bit multiplexer.
//   in  [7:0] - data inputs
//   sel [2:0] - input select
//   out       - in[sel]
module mux81 (
    input  logic [7:0] in,
    input  logic [2:0] sel,
    output logic       out
);

    assign out = in[sel];

endmodule

// File: rtl/mux81_rr_sched.sv
// mux81_rr_sched: round-robin scheduler sharing one 8:1 mux among eight
// requesters, with each grant bounded to MAX_HOLD consecutive cycles.
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   req   - per-requester level request
//   din   - per-requester data bit
//   grant - registered one-hot grant (all-zero when idle)
//   sel   - registered index of the current owner
//   busy  - registered, high while a grant is active
//   dout  - din[sel] while busy, else 0 (combinational from din)
module mux81_rr_sched
    import mux81_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] din,
    output logic [NREQ-1:0] grant,
    output logic [SELW-1:0] sel,
    output logic            busy,
    output logic            dout
);

    state_t          state, state_n;
    logic [NREQ-1:0] grant_n;
    logic [SELW-1:0] sel_n;
    logic [SELW-1:0] ptr, ptr_n;
    logic [3:0]      hold_cnt, hold_n;

    logic            release_owner;
    logic [SELW-1:0] search_start;
    logic [SELW:0]   pick;
    logic            mux_out;

    // On release the pointer moves to sel+1 and the search starts there in
    // the same cycle, so the search start is muxed rather than read from ptr.
    assign release_owner = !req[sel] || (hold_cnt == 4'(MAX_HOLD - 1));
    assign search_start  = (state == GRANT) ? sel + 1'b1 : ptr;
    assign pick          = rr_pick(req, search_start);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            sel      <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            sel      <= sel_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
        end
    end

    always_comb begin
        state_n = state;
        grant_n = grant;
        sel_n   = sel;
        ptr_n   = ptr;
        hold_n  = hold_cnt;
        unique case (state)
            IDLE: begin
                if (pick[SELW]) begin
                    sel_n   = pick[SELW-1:0];
                    grant_n = NREQ'(1) << pick[SELW-1:0];
                    hold_n  = '0;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (!release_owner) begin
                    hold_n = hold_cnt + 4'd1;
                end else begin
                    ptr_n  = search_start;
                    hold_n = '0;
                    if (pick[SELW]) begin
                        sel_n   = pick[SELW-1:0];
                        grant_n = NREQ'(1) << pick[SELW-1:0];
                    end else begin
                        grant_n = '0;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    assign busy = (state == GRANT);

    mux81 u_mux81 (
        .in  (din),
        .sel (sel),
        .out (mux_out)
    );

    assign dout = mux_out & busy;

endmodule

// File: tb/tb_mux81_rr_sched.sv
module tb_mux81_rr_sched;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] din;

    logic [7:0] g1, g2;
    logic [2:0] s1, s2;
    logic       b1, b2, o1, o2;

    int checks = 0;
    int errors = 0;

    // Reference model: owner (-1 when idle), cycles held so far, search start
    int own   [2];
    int held  [2];
    int start [2];
    int lsel  [2];
    int mh    [2] = '{4, 2};

    mux81_rr_sched #(.MAX_HOLD(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .din(din),
        .grant(g1), .sel(s1), .busy(b1), .dout(o1)
    );

    mux81_rr_sched #(.MAX_HOLD(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req(req), .din(din),
        .grant(g2), .sel(s2), .busy(b2), .dout(o2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int find(input logic [7:0] rq, input int s);
        for (int off = 0; off < 8; off++) begin
            if (rq[(s + off) % 8]) return (s + off) % 8;
        end
        return -1;
    endfunction

    task automatic model_step(input int i);
        int w;
        if (!rst_n) begin
            own[i] = -1; held[i] = 0; start[i] = 0; lsel[i] = 0;
        end else if (own[i] < 0) begin
            w = find(req, start[i]);
            if (w >= 0) begin own[i] = w; held[i] = 1; lsel[i] = w; end
        end else if (req[own[i]] && held[i] < mh[i]) begin
            held[i]++;
        end else begin
            start[i] = (own[i] + 1) % 8;
            w = find(req, start[i]);
            if (w >= 0) begin own[i] = w; held[i] = 1; lsel[i] = w; end
            else own[i] = -1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        logic [7:0] eg;
        logic       eb, eo;
        for (int i = 0; i < 2; i++) begin
            eg = (own[i] >= 0) ? (8'd1 << own[i]) : 8'd0;
            eb = (own[i] >= 0);
            eo = eb ? din[lsel[i]] : 1'b0;
            if (i == 0) begin
                chk("grant4", g1, eg); chk("sel4", {5'd0, s1}, 8'(lsel[i]));
                chk("busy4", {7'd0, b1}, {7'd0, eb}); chk("dout4", {7'd0, o1}, {7'd0, eo});
            end else begin
                chk("grant2", g2, eg); chk("sel2", {5'd0, s2}, 8'(lsel[i]));
                chk("busy2", {7'd0, b2}, {7'd0, eb}); chk("dout2", {7'd0, o2}, {7'd0, eo});
            end
        end
        chk("onehot4", {7'd0, (g1 == 8'd0) || $onehot(g1)}, 8'd1);
        chk("onehot2", {7'd0, (g2 == 8'd0) || $onehot(g2)}, 8'd1);
    endtask

    task automatic step(input logic r, input logic [7:0] rq, input logic [7:0] d);
        rst_n = r; req = rq; din = d;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare_all();
    endtask

    initial begin
        logic [7:0] rq;
        rst_n = 1'b0; req = '0; din = '0;
        for (int i = 0; i < 2; i++) begin own[i] = -1; held[i] = 0; start[i] = 0; lsel[i] = 0; end

        // Reset state
        step(1'b0, 8'h00, 8'hFF);
        step(1'b0, 8'h00, 8'hFF);
        chk("reset_grant", g1, 8'h00);
        chk("reset_busy_dout", {6'd0, b1, o1}, 8'h00);

        // Reset mid-grant with owner 3
        step(1'b1, 8'h08, 8'hFF);
        chk("owner3_grant", g1, 8'h08);
        step(1'b1, 8'h08, 8'hFF);
        step(1'b0, 8'h08, 8'hFF);
        chk("midrst_grant", g1, 8'h00);
        chk("midrst_sel", {5'd0, s1}, 8'h00);
        chk("midrst_busy_dout", {6'd0, b1, o1}, 8'h00);
        step(1'b1, 8'h01, 8'hFF);
        chk("after_rst_grant", g1, 8'h01);

        // Single requester 5 held: continuous grant across quantum expiry
        step(1'b0, 8'h00, 8'h20);
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 8'h20, 8'h20);
            chk("single_grant", g1, 8'h20);
            chk("single_sel", {5'd0, s1}, 8'd5);
        end

        // Full load rotation; MAX_HOLD=2 instance gives 0,0,1,1,...,7,7,0,0
        step(1'b0, 8'h00, 8'hAA);
        for (int c = 0; c < 18; c++) begin
            step(1'b1, 8'hFF, 8'hAA);
            chk("rot_sel2", {5'd0, s2}, 8'((c / 2) % 8));
        end

        // Early release, back-to-back handoff 2 -> 7, then idle
        step(1'b0, 8'h00, 8'h80);
        step(1'b1, 8'h04, 8'h80);
        step(1'b1, 8'h84, 8'h80);
        step(1'b1, 8'h80, 8'h80);
        chk("handoff_grant", g1, 8'h80);
        chk("handoff_busy", {7'd0, b1}, 8'd1);
        step(1'b1, 8'h00, 8'h80);
        chk("drain_busy", {7'd0, b1}, 8'd0);
        chk("drain_dout", {7'd0, o1}, 8'd0);

        // Wrap: owner 6 expires with req=41 -> scan 7,0 picks 0
        step(1'b0, 8'h00, 8'h00);
        step(1'b1, 8'h40, 8'h00);
        for (int c = 0; c < 4; c++) step(1'b1, 8'h41, 8'h00);
        chk("wrap_grant", g1, 8'h01);

        // Data path with alternating din over a full rotation
        step(1'b0, 8'h00, 8'b10101010);
        for (int c = 0; c < 34; c++) begin
            step(1'b1, 8'hFF, 8'b10101010);
            chk("data_dout4", {7'd0, o1}, {7'd0, s1[0]});
        end

        // Randomized traffic
        rq = 8'h00;
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
            end
            step(($urandom_range(0, 63) != 0), rq, 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
